// File: rtl/pool_pkg.sv
// Shared definitions for the pooling window unit.
//   MODE_MAX / MODE_AVG : reduction mode encoding on the mode port.
//   state_t             : FSM encoding (ST_ACC accumulate, ST_RES result pending).
//   clog2 / pow2_ge2    : elaboration-time helpers for sizing and legality checks.
package pool_pkg;
   localparam logic MODE_MAX = 1'b0;
   localparam logic MODE_AVG = 1'b1;

   typedef enum logic {ST_ACC = 1'b0, ST_RES = 1'b1} state_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   function automatic bit pow2_ge2(input int k);
      return (k >= 2) && ((k & (k - 1)) == 0);
   endfunction
endpackage

// File: rtl/pool_acc.sv
// Window accumulator datapath: running signed max and running sum.
//   clk, rst : clock and synchronous active-high reset
//   load     : start a window with data
//   step     : fold data into the running max/sum
//   fin      : last sample; accumulators return to zero
//   mode     : latched window mode selecting what result reports
//   data     : incoming signed sample
//   result   : final reduction including the current data sample
module pool_acc
   import pool_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     load,
   input  logic                     step,
   input  logic                     fin,
   input  logic                     mode,
   input  logic signed [DATA_W-1:0] data,
   output logic signed [DATA_W-1:0] result
);
   localparam int SUM_W = DATA_W + CNT_W;

   logic signed [DATA_W-1:0] acc_max, nxt_max;
   logic signed [SUM_W-1:0]  acc_sum, nxt_sum, data_ext;

   assign data_ext = {{CNT_W{data[DATA_W-1]}}, data};
   // Ties keep the accumulator.
   assign nxt_max  = (acc_max >= data) ? acc_max : data;
   assign nxt_sum  = acc_sum + data_ext;

   // Floor average: the low DATA_W bits of (nxt_sum >>> CNT_W) are exactly
   // the top DATA_W bits of nxt_sum, and the mean always fits DATA_W.
   assign result = (mode == MODE_AVG) ? nxt_sum[CNT_W +: DATA_W] : nxt_max;

   always_ff @(posedge clk) begin
      if (rst || fin) begin
         acc_max <= '0;
         acc_sum <= '0;
      end else if (load) begin
         acc_max <= data;
         acc_sum <= data_ext;
      end else if (step) begin
         acc_max <= nxt_max;
         acc_sum <= nxt_sum;
      end
   end
endmodule

// File: rtl/pool_window_unit.sv
// Streaming POOL_K x POOL_K pooling reducer (max or floor-average).
//   clk, rst   : clock, synchronous active-high reset
//   clear      : abort partial window (ACC) or drop pending result (RES)
//   mode       : 0 max, 1 average; latched with the first sample of a window
//   in_valid / in_ready / in_data    : sample handshake
//   out_valid / out_ready / out_data : result handshake
//   busy       : partial window held or result pending
module pool_window_unit
   import pool_pkg::*;
#(
   parameter  int DATA_W = 8,
   parameter  int POOL_K = 2,
   localparam int N      = POOL_K * POOL_K,
   localparam int CNT_W  = clog2(N)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     mode,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [DATA_W-1:0] out_data,
   output logic                     busy
);
   if (!pow2_ge2(POOL_K)) begin : g_bad_k
      $error("pool_window_unit: POOL_K must be a power of two >= 2");
   end

   state_t                   state, state_nxt;
   logic [CNT_W-1:0]         count;
   logic                     mode_q;
   logic                     take, first, last, done;
   logic signed [DATA_W-1:0] result;

   // A sample presented during clear is dropped.
   assign take  = in_valid && in_ready && !clear;
   assign first = take && (count == '0);
   assign last  = take && (count == CNT_W'(N - 1));
   assign done  = out_valid && out_ready;
   assign busy  = (count != '0) || (state == ST_RES);

   always_ff @(posedge clk) begin
      if (rst) state <= ST_ACC;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         ST_ACC: begin
            in_ready = 1'b1;
            if (last) state_nxt = ST_RES;
         end
         ST_RES: begin
            out_valid = 1'b1;
            if (clear || done) state_nxt = ST_ACC;
         end
         default: state_nxt = ST_ACC;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count    <= '0;
         mode_q   <= MODE_MAX;
         out_data <= '0;
      end else begin
         if ((clear && state == ST_ACC) || last) count <= '0;
         else if (take)                          count <= count + 1'b1;
         if (first) mode_q   <= mode;
         if (last)  out_data <= result;
      end
   end

   pool_acc #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_acc (
      .clk    (clk),
      .rst    (rst),
      .load   (first),
      .step   (take && !first && !last),
      .fin    (last),
      .mode   (mode_q),
      .data   (in_data),
      .result (result)
   );
endmodule

// File: tb/tb_pool_window_unit.sv
module tb_pool_window_unit;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // K=2 instance
   logic rst2, clear2, mode2, iv2, ir2, ov2, ordy2, busy2;
   logic signed [7:0] id2, od2;
   // K=4 instance
   logic rst4, clear4, mode4, iv4, ir4, ov4, ordy4, busy4;
   logic signed [7:0] id4, od4;

   pool_window_unit #(.DATA_W(8), .POOL_K(2)) dut2 (
      .clk(clk), .rst(rst2), .clear(clear2), .mode(mode2),
      .in_valid(iv2), .in_ready(ir2), .in_data(id2),
      .out_valid(ov2), .out_ready(ordy2), .out_data(od2), .busy(busy2));

   pool_window_unit #(.DATA_W(8), .POOL_K(4)) dut4 (
      .clk(clk), .rst(rst4), .clear(clear4), .mode(mode4),
      .in_valid(iv4), .in_ready(ir4), .in_data(id4),
      .out_valid(ov4), .out_ready(ordy4), .out_data(od4), .busy(busy4));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Feed one K=2 window back-to-back; mode m0 on the first sample, m1 after.
   // Returns #1 after the edge accepting the last sample.
   task automatic feed2(input logic m0, input logic m1,
                        input logic signed [7:0] a, b, c, d);
      logic signed [7:0] v [4];
      v = '{a, b, c, d};
      for (int i = 0; i < 4; i++) begin
         iv2 = 1'b1; id2 = v[i]; mode2 = (i == 0) ? m0 : m1;
         tick();
      end
      iv2 = 1'b0;
   endtask

   task automatic test_reset();
      rst2 = 1'b1; rst4 = 1'b1;
      tick(); tick();
      checks += 8;
      if (ir2 !== 1'b1)   begin errors++; $display("FAIL reset_ir2: got %b expected 1", ir2); end
      if (ov2 !== 1'b0)   begin errors++; $display("FAIL reset_ov2: got %b expected 0", ov2); end
      if (od2 !== 8'sd0)  begin errors++; $display("FAIL reset_od2: got %0d expected 0", od2); end
      if (busy2 !== 1'b0) begin errors++; $display("FAIL reset_busy2: got %b expected 0", busy2); end
      if (ir4 !== 1'b1)   begin errors++; $display("FAIL reset_ir4: got %b expected 1", ir4); end
      if (ov4 !== 1'b0)   begin errors++; $display("FAIL reset_ov4: got %b expected 0", ov4); end
      if (od4 !== 8'sd0)  begin errors++; $display("FAIL reset_od4: got %0d expected 0", od4); end
      if (busy4 !== 1'b0) begin errors++; $display("FAIL reset_busy4: got %b expected 0", busy4); end
      rst2 = 1'b0; rst4 = 1'b0;
   endtask

   task automatic test_max_back_to_back();
      ordy2 = 1'b1;
      feed2(1'b0, 1'b0, -8'sd3, 8'sd5, 8'sd2, -8'sd128);
      checks += 3;
      if (ov2 !== 1'b1)  begin errors++; $display("FAIL max_ov: got %b expected 1", ov2); end
      if (od2 !== 8'sd5) begin errors++; $display("FAIL max_data: got %0d expected 5", od2); end
      if (ir2 !== 1'b0)  begin errors++; $display("FAIL max_ir_low: got %b expected 0", ir2); end
      tick();
      checks += 2;
      if (ir2 !== 1'b1)  begin errors++; $display("FAIL max_ir_back: got %b expected 1", ir2); end
      if (ov2 !== 1'b0)  begin errors++; $display("FAIL max_ov_clr: got %b expected 0", ov2); end
   endtask

   task automatic test_avg();
      feed2(1'b1, 1'b1, -8'sd1, -8'sd2, -8'sd3, -8'sd4);
      checks++;
      if (od2 !== -8'sd3) begin errors++; $display("FAIL avg_neg_floor: got %0d expected -3", od2); end
      tick();
      feed2(1'b1, 1'b1, 8'sd127, 8'sd127, 8'sd127, 8'sd127);
      checks++;
      if (od2 !== 8'sd127) begin errors++; $display("FAIL avg_pos_max: got %0d expected 127", od2); end
      tick();
      feed2(1'b1, 1'b1, -8'sd128, -8'sd128, -8'sd128, -8'sd128);
      checks++;
      if (od2 !== -8'sd128) begin errors++; $display("FAIL avg_neg_min: got %0d expected -128", od2); end
      tick();
   endtask

   task automatic test_backpressure();
      ordy2 = 1'b0;
      feed2(1'b0, 1'b0, 8'sd10, 8'sd40, 8'sd30, 8'sd20);
      for (int i = 0; i < 5; i++) begin
         iv2 = 1'b1; id2 = 8'sd99;
         checks += 3;
         if (ov2 !== 1'b1)   begin errors++; $display("FAIL bp_ov[%0d]: got %b expected 1", i, ov2); end
         if (od2 !== 8'sd40) begin errors++; $display("FAIL bp_data[%0d]: got %0d expected 40", i, od2); end
         if (ir2 !== 1'b0)   begin errors++; $display("FAIL bp_ir[%0d]: got %b expected 0", i, ir2); end
         tick();
      end
      iv2 = 1'b0; ordy2 = 1'b1;
      tick();
      checks += 2;
      if (ov2 !== 1'b0)   begin errors++; $display("FAIL bp_release: got %b expected 0", ov2); end
      if (busy2 !== 1'b0) begin errors++; $display("FAIL bp_no_consume: got %b expected 0", busy2); end
   endtask

   task automatic test_mode_latch();
      feed2(1'b0, 1'b1, 8'sd1, 8'sd9, 8'sd3, 8'sd4);
      checks++;
      if (od2 !== 8'sd9) begin errors++; $display("FAIL mode_latch: got %0d expected 9", od2); end
      tick();
   endtask

   task automatic test_clear();
      mode2 = 1'b0;
      iv2 = 1'b1; id2 = 8'sd7; tick();
      iv2 = 1'b1; id2 = 8'sd8; tick();
      checks++;
      if (busy2 !== 1'b1) begin errors++; $display("FAIL clr_busy_before: got %b expected 1", busy2); end
      clear2 = 1'b1; iv2 = 1'b1; id2 = 8'sd100; tick();
      clear2 = 1'b0; iv2 = 1'b0;
      checks += 2;
      if (busy2 !== 1'b0) begin errors++; $display("FAIL clr_busy: got %b expected 0", busy2); end
      if (ir2 !== 1'b1)   begin errors++; $display("FAIL clr_ir: got %b expected 1", ir2); end
      feed2(1'b0, 1'b0, 8'sd1, 8'sd2, 8'sd3, 8'sd4);
      checks++;
      if (od2 !== 8'sd4) begin errors++; $display("FAIL clr_next_window: got %0d expected 4", od2); end
      tick();
      // clear while a result is pending discards it
      ordy2 = 1'b0;
      feed2(1'b0, 1'b0, 8'sd5, 8'sd6, 8'sd7, 8'sd8);
      clear2 = 1'b1; tick(); clear2 = 1'b0;
      checks += 3;
      if (ov2 !== 1'b0)   begin errors++; $display("FAIL clr_res_ov: got %b expected 0", ov2); end
      if (busy2 !== 1'b0) begin errors++; $display("FAIL clr_res_busy: got %b expected 0", busy2); end
      if (ir2 !== 1'b1)   begin errors++; $display("FAIL clr_res_ir: got %b expected 1", ir2); end
      ordy2 = 1'b1;
   endtask

   task automatic test_k4_and_rst();
      ordy4 = 1'b1; mode4 = 1'b1;
      for (int i = 0; i < 16; i++) begin
         iv4 = 1'b1; id4 = 8'(i); tick();
      end
      iv4 = 1'b0;
      checks += 2;
      if (ov4 !== 1'b1)  begin errors++; $display("FAIL k4_ov: got %b expected 1", ov4); end
      if (od4 !== 8'sd7) begin errors++; $display("FAIL k4_avg: got %0d expected 7", od4); end
      tick();
      for (int i = 0; i < 6; i++) begin
         iv4 = 1'b1; id4 = 8'(i); tick();
      end
      iv4 = 1'b0;
      checks++;
      if (busy4 !== 1'b1) begin errors++; $display("FAIL k4_partial_busy: got %b expected 1", busy4); end
      rst4 = 1'b1; tick(); rst4 = 1'b0;
      checks += 4;
      if (od4 !== 8'sd0)  begin errors++; $display("FAIL k4_rst_od: got %0d expected 0", od4); end
      if (busy4 !== 1'b0) begin errors++; $display("FAIL k4_rst_busy: got %b expected 0", busy4); end
      if (ir4 !== 1'b1)   begin errors++; $display("FAIL k4_rst_ir: got %b expected 1", ir4); end
      if (ov4 !== 1'b0)   begin errors++; $display("FAIL k4_rst_ov: got %b expected 0", ov4); end
      for (int i = 0; i < 16; i++) begin
         iv4 = 1'b1; id4 = -8'sd1; mode4 = 1'b1; tick();
      end
      iv4 = 1'b0;
      checks += 2;
      if (ov4 !== 1'b1)   begin errors++; $display("FAIL k4_after_rst_ov: got %b expected 1", ov4); end
      if (od4 !== -8'sd1) begin errors++; $display("FAIL k4_after_rst: got %0d expected -1", od4); end
      tick();
   endtask

   initial begin
      rst2 = 1'b1; clear2 = 1'b0; mode2 = 1'b0; iv2 = 1'b0; id2 = '0; ordy2 = 1'b1;
      rst4 = 1'b1; clear4 = 1'b0; mode4 = 1'b0; iv4 = 1'b0; id4 = '0; ordy4 = 1'b1;
      test_reset();
      test_max_back_to_back();
      test_avg();
      test_backpressure();
      test_mode_latch();
      test_clear();
      test_k4_and_rst();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
